// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int N            = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Handshake: req[i] is held by requester i until it sees gnt[i]; it keeps the
// resource while req[i] stays high and done is low, and gnt falls one edge after release.
interface rr_arbiter_8_if;
    import arb_pkg::*;

    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (output req, done, input gnt, gnt_idx, gnt_valid);
    modport slave  (input req, done, output gnt, gnt_idx, gnt_valid);
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first set bit of req at or above ptr, with wrap.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        // Rotate right so bit ptr lands at position 0, then take the lowest set bit.
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        idx = off + ptr;
        any = |req;
    end
endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters: registered one-hot grant, held until
// done, request drop, or hold-limit expiry while others wait.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
)
(
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_8_if.slave  bus,
    output arb_state_e     dbg_state
);
    localparam int              HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             limit_hit;
    logic             rel;

    rr_pick u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        // Hold limit only bites when someone other than the owner is waiting.
        limit_hit = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && ((bus.req & ~gnt_q) != '0);
        rel       = bus.done || !bus.req[owner_q] || limit_hit;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx + IDX_W'(1);
                    hold_d  = HOLD_W'(1);
                    gnt_d   = N'(1) << pick_idx;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8 (MAX_HOLD=4): directed scenarios plus random traffic
// against a cycle-level reference model of the arbitration rules.
module tb_rr_arbiter_8;
    import arb_pkg::*;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    arb_state_e dbg_state;

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource, for how long, and where the search starts.
    bit  m_busy  = 0;
    int  m_owner = 0;
    int  m_hold  = 0;
    int  m_ptr   = 0;

    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [7:0] r, input logic d, input logic rs);
        int  w;
        bit  others;
        if (rs) begin
            m_busy = 0; m_owner = 0; m_hold = 0; m_ptr = 0;
        end else if (!m_busy) begin
            w = first_from(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_hold = 1; m_ptr = (w + 1) % 8;
            end
        end else begin
            others = (r & ~(8'd1 << m_owner)) != 8'd0;
            if (d || !r[m_owner] || (m_hold == MH && others)) begin
                m_busy = 0; m_hold = 0;
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
        exp_q.push_back({m_busy, (m_busy ? 3'(m_owner) : 3'd0),
                         (m_busy ? (8'd1 << m_owner) : 8'd0)});
    endtask

    // One clock: apply inputs, advance the model, sample outputs #1 after the edge.
    task automatic step(input logic [7:0] r, input logic d, input logic rs);
        logic [11:0] e;
        bus.req  = r;
        bus.done = d;
        rst      = rs;
        model_step(r, d, rs);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("gnt",       32'(bus.gnt),       32'(e[7:0]));
        check("gnt_idx",   32'(bus.gnt_idx),   32'(e[10:8]));
        check("gnt_valid", 32'(bus.gnt_valid), 32'(e[11]));
        check("state",     32'(dbg_state),     32'(e[11]));
    endtask

    task automatic do_reset();
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] r;
        logic       d;
        logic       rs;
        bus.req  = '0;
        bus.done = 1'b0;
        #1;

        // Reset with all requesting, then first grant to requester 0.
        step(8'hFF, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b1);
        check("reset_gnt", 32'(bus.gnt), 32'h0);
        check("reset_valid", 32'(bus.gnt_valid), 32'h0);
        step(8'hFF, 1'b0, 1'b0);
        check("first_gnt", 32'(bus.gnt), 32'h01);

        // Rotation with wrap of the pointer.
        do_reset();
        step(8'h81, 1'b0, 1'b0);
        check("rot_a", 32'(bus.gnt_idx), 32'd0);
        step(8'h81, 1'b1, 1'b0);
        check("rot_gap", 32'(bus.gnt), 32'h0);
        step(8'h81, 1'b0, 1'b0);
        check("rot_b", 32'(bus.gnt), 32'h80);
        check("rot_b_idx", 32'(bus.gnt_idx), 32'd7);
        step(8'h81, 1'b1, 1'b0);
        step(8'h81, 1'b0, 1'b0);
        check("rot_wrap", 32'(bus.gnt_idx), 32'd0);

        // Fairness: all requesting, done on each grant's first cycle.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b0, 1'b0);
            check("fair_idx", 32'(bus.gnt_idx), 32'(k % 8));
            step(8'hFF, 1'b1, 1'b0);
            check("fair_gap", 32'(bus.gnt_valid), 32'h0);
        end

        // Hold limit with a competitor waiting.
        do_reset();
        for (int k = 0; k < MH; k++) begin
            step(8'h03, 1'b0, 1'b0);
            check("hold_own", 32'({bus.gnt_valid, bus.gnt_idx}), 32'({1'b1, 3'd0}));
        end
        step(8'h03, 1'b0, 1'b0);
        check("hold_gap", 32'(bus.gnt_valid), 32'h0);
        step(8'h03, 1'b0, 1'b0);
        check("hold_next", 32'(bus.gnt_idx), 32'd1);

        // Sole requester keeps the grant indefinitely.
        do_reset();
        for (int k = 0; k < 24; k++) step(8'h01, 1'b0, 1'b0);
        check("hold_solo", 32'(bus.gnt), 32'h01);

        // Request drop, then done while idle.
        do_reset();
        step(8'h04, 1'b0, 1'b0);
        check("drop_own", 32'(bus.gnt), 32'h04);
        step(8'h00, 1'b0, 1'b0);
        check("drop_rel", 32'(bus.gnt), 32'h00);
        step(8'h00, 1'b1, 1'b0);
        check("idle_done", 32'(bus.gnt_valid), 32'h0);

        // Reset mid-grant returns the pointer to 0.
        do_reset();
        step(8'h20, 1'b0, 1'b0);
        check("mid_own", 32'(bus.gnt), 32'h20);
        step(8'h20, 1'b0, 1'b1);
        check("mid_rst", 32'(bus.gnt), 32'h00);
        step(8'h21, 1'b0, 1'b0);
        check("mid_after", 32'(bus.gnt_idx), 32'd0);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            r  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            d  = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(r, d, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among 8 requesters. It sits in front of the shared path and uses an 8-to-3 priority pick with a rotating starting point, so no requester is starved. A grant is held until the owner signals completion, drops its request, or exceeds a hold limit while others are waiting. It outputs a one-hot grant, its encoded index and a valid flag.

## Interface
- `N`, 8: number of requesters; fixed at 8 for this block.
- `IDX_W`, 3: width of the grant index.
- `MAX_HOLD`, 16: maximum consecutive grant cycles while other requests are pending. 0 disables the limit.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  8  request vector; bit i = requester i wants the resource.
- `done`  in  1  the current owner finishes; honoured only in GRANT.
- `gnt`  out  8  one-hot grant, registered.
- `gnt_idx`  out  3  binary index of the grant bit; 0 when idle.
- `gnt_valid`  out  1  high exactly when `gnt` is nonzero.

## Operation
- Two states: IDLE and GRANT. Internal state:
  - rotate pointer `ptr` (3 bits),
  - owner index,
  - hold counter (width clog2(MAX_HOLD+1), saturating).
- Pick rule: the winner is the first set bit of `req`, searching upward from `ptr` with wrap (ptr, ptr+1, …, 7, 0, …, ptr-1).
- IDLE:
  - `req`==0: stay in IDLE.
  - Otherwise register the winner: `gnt`=1<<w, `gnt_idx`=w, `gnt_valid`=1.
  - Set `ptr`=(w+1) mod 8, hold counter=1, go to GRANT.
- GRANT: the grant is released when any of these holds:
  - (a) `done`=1;
  - (b) `req[owner]`=0;
  - (c) MAX_HOLD≠0, hold counter==MAX_HOLD, and (`req` & ~`gnt`)≠0.
- On release, the next edge clears `gnt`/`gnt_idx`/`gnt_valid` and returns to IDLE. The next grant comes no earlier than the edge after that (one turnaround cycle).
- With no release condition, the grant holds and the counter increments, saturating at MAX_HOLD.
- With only the owner requesting, the grant is held indefinitely.
- `done` in IDLE is ignored.
- `ptr` changes only when a grant is issued. Release does not change `ptr`.
- 3-bit index arithmetic wraps mod 8: owner 7 gives `ptr`=0.

## Timing
- Reset values: `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, state IDLE, `ptr`=0, hold counter=0.
- `rst` overrides everything, including mid-grant. Outputs are zero on the cycle after the `rst` edge.
- Grant latency: `req` sampled at edge t in IDLE → `gnt` valid after edge t.
- Release latency: a condition true at edge t → `gnt`=0 after edge t.
- Back-to-back grants are separated by exactly one idle cycle when requests stay pending.
- Outputs are pure registers; there is no combinational path from `req`/`done` to the outputs.
- Simultaneous `done` and a new `req` from another requester: release first, re-arbitrate in IDLE on the following edge.

## Structure
- Shared package `arb_pkg`: N, IDX_W, state encodings (IDLE=0, GRANT=1), MAX_HOLD default.
- One sub-module `rr_pick`: combinational.
  - Inputs `req[7:0]`, `ptr[2:0]`; outputs `idx[2:0]`, `any`.
  - Implementation: rotate `req` right by `ptr`, priority-encode lowest set bit, add `ptr` mod 8.
- Top holds the FSM, `ptr`, owner and hold counter.

## Test plan
- Reset: hold `rst` 2 cycles with `req`=8'hFF → `gnt`=0, `gnt_idx`=0, `gnt_valid`=0. One cycle after release: `gnt`=8'b00000001.
- Rotation after reset:
  - `req`=8'b10000001 → `gnt`=8'b00000001, `gnt_idx`=0.
  - Pulse `done` → one cycle of `gnt`=0, then `gnt`=8'b10000000, `gnt_idx`=7.
  - Pulse `done` again → next winner is 0 (`ptr` wrapped to 0).
- Fairness: `req`=8'hFF held, `done` pulsed on each grant's first cycle → `gnt_idx` sequence 0,1,2,3,4,5,6,7,0, with an idle cycle between each.
- Hold limit (MAX_HOLD=4):
  - `req`=8'b00000011, no `done` → `gnt_idx`=0 for exactly 4 cycles, one idle cycle, then `gnt_idx`=1.
  - Repeat with `req`=8'b00000001 → grant 0 held 20+ cycles.
- Request drop: owner 2 (`req`=8'b00000100) deasserts `req[2]` → `gnt`=0 next cycle. `done`=1 in IDLE → no change.
- Mid-grant reset: `gnt`=8'b00100000, assert `rst` → `gnt`=0 next cycle. After reset with `req`=8'b00100001, winner is 0 (`ptr` back to 0).
